// File: rtl/cricket_pkg.sv
// Shared types and defaults for the cricket scoring datapath.
package cricket_pkg;

  localparam int DEFAULT_BALLS_PER_OVER = 6;
  localparam int DEFAULT_MAX_OVERS      = 20;

  typedef logic [2:0] ball_cnt_t;

endpackage : cricket_pkg

// File: rtl/ball_counter_rise_detect.sv
// Rising-edge detector: registers d and flags the cycle where d is high but was low.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (reset) d_q <= 1'b0;
    else       d_q <= d;
  end

  // Combinational on purpose so the counter reacts at the edge that first samples d high.
  assign pulse = d & ~d_q;

endmodule : rise_detect

// File: rtl/ball_counter.sv
// Counts legal deliveries from a ball_bowled level; tracks balls in the over and completed overs.
module ball_counter
  import cricket_pkg::*;
#(
  parameter int BALLS_PER_OVER = DEFAULT_BALLS_PER_OVER,
  parameter int MAX_OVERS      = DEFAULT_MAX_OVERS,
  parameter int OVER_W         = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ball_bowled,
  output ball_cnt_t         count,
  output logic [OVER_W-1:0] overs,
  output logic              over_done,
  output logic              innings_done
);

  if (BALLS_PER_OVER < 2 || BALLS_PER_OVER > 7) begin : g_bad_balls
    $fatal(1, "ball_counter: BALLS_PER_OVER must be in 2..7");
  end
  if (MAX_OVERS < 1 || MAX_OVERS >= (2 ** OVER_W)) begin : g_bad_overs
    $fatal(1, "ball_counter: MAX_OVERS must be in 1..2**OVER_W-1");
  end

  localparam ball_cnt_t         LAST_BALL = ball_cnt_t'(BALLS_PER_OVER - 1);
  localparam logic [OVER_W-1:0] OVER_LIM  = OVER_W'(MAX_OVERS);

  logic ball_evt;

  rise_detect u_rise_detect (
    .clk   (clk),
    .reset (reset),
    .d     (ball_bowled),
    .pulse (ball_evt)
  );

  logic [OVER_W-1:0] overs_next;
  assign overs_next = overs + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      count        <= '0;
      overs        <= '0;
      over_done    <= 1'b0;
      innings_done <= 1'b0;
    end else begin
      over_done <= 1'b0;
      // Once the innings is closed every delivery is ignored until reset.
      if (ball_evt && !innings_done) begin
        if (count < LAST_BALL) begin
          count <= count + 3'd1;
        end else begin
          count     <= '0;
          overs     <= overs_next;
          over_done <= 1'b1;
          if (overs_next == OVER_LIM) innings_done <= 1'b1;
        end
      end
    end
  end

endmodule : ball_counter

// File: tb/tb_ball_counter.sv
// Directed bench for ball_counter: default instance plus a two-over instance for innings end.
module tb_ball_counter;

  logic       clk = 1'b0;
  logic       rst, ball;
  logic       rst2, ball2;
  logic [2:0] count, count2;
  logic [5:0] overs, overs2;
  logic       over_done, over_done2, inn_done, inn_done2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ball_counter #(.BALLS_PER_OVER(6), .MAX_OVERS(20), .OVER_W(6)) dut (
    .clk(clk), .reset(rst), .ball_bowled(ball),
    .count(count), .overs(overs), .over_done(over_done), .innings_done(inn_done)
  );

  ball_counter #(.BALLS_PER_OVER(6), .MAX_OVERS(2), .OVER_W(6)) dut2 (
    .clk(clk), .reset(rst2), .ball_bowled(ball2),
    .count(count2), .overs(overs2), .over_done(over_done2), .innings_done(inn_done2)
  );

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst2 = 1'b1; ball = 1'b0; ball2 = 1'b0;
    tick(); tick();
    tests++;
    if ({count, overs, over_done, inn_done} !== {3'd0, 6'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_dut: count=%0d overs=%0d od=%0b id=%0b required 0/0/0/0",
               count, overs, over_done, inn_done);
    end
    tests++;
    if ({count2, overs2, over_done2, inn_done2} !== {3'd0, 6'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_dut2: count=%0d overs=%0d od=%0b id=%0b required 0/0/0/0",
               count2, overs2, over_done2, inn_done2);
    end
    rst = 1'b0; rst2 = 1'b0;
    tick();
  endtask

  task automatic test_strobes();
    logic [2:0] exp_count [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2};
    logic [5:0] exp_overs [8] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd1, 6'd1, 6'd1};
    int pulses = 0;
    for (int i = 0; i < 8; i++) begin
      ball = 1'b1;
      tick();
      tests++;
      if (count !== exp_count[i] || overs !== exp_overs[i]) begin
        fails++;
        $display("FAIL strobe_%0d: count=%0d overs=%0d required %0d/%0d",
                 i + 1, count, overs, exp_count[i], exp_overs[i]);
      end
      tests++;
      if (over_done !== (i == 5)) begin
        fails++;
        $display("FAIL strobe_od_%0d: over_done=%0b required %0b", i + 1, over_done, i == 5);
      end
      if (over_done === 1'b1) pulses++;
      ball = 1'b0;
      tick();
      if (over_done === 1'b1) pulses++;
    end
    tests++;
    if (pulses != 1) begin
      fails++;
      $display("FAIL over_done_pulses: got %0d required 1", pulses);
    end
  endtask

  task automatic test_hold();
    ball = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (count !== 3'd3 || overs !== 6'd1) begin
        fails++;
        $display("FAIL hold_cycle_%0d: count=%0d overs=%0d required 3/1", i, count, overs);
      end
    end
    ball = 1'b0;
    tick();
  endtask

  task automatic test_reset_priority();
    rst = 1'b1; ball = 1'b1;
    tick();
    tests++;
    if (count !== 3'd0 || overs !== 6'd0 || over_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_priority: count=%0d overs=%0d od=%0b required 0/0/0",
               count, overs, over_done);
    end
    rst = 1'b0; ball = 1'b0;
    tick();
    tests++;
    if (count !== 3'd0) begin
      fails++;
      $display("FAIL reset_priority_after: count=%0d required 0", count);
    end
  endtask

  task automatic test_innings_end();
    for (int i = 1; i <= 13; i++) begin
      ball2 = 1'b1;
      tick();
      if (i == 12) begin
        tests++;
        if (overs2 !== 6'd2 || inn_done2 !== 1'b1 || count2 !== 3'd0 || over_done2 !== 1'b1) begin
          fails++;
          $display("FAIL innings_end: overs=%0d id=%0b count=%0d od=%0b required 2/1/0/1",
                   overs2, inn_done2, count2, over_done2);
        end
      end
      if (i == 11) begin
        tests++;
        if (inn_done2 !== 1'b0 || overs2 !== 6'd1 || count2 !== 3'd5) begin
          fails++;
          $display("FAIL innings_early: id=%0b overs=%0d count=%0d required 0/1/5",
                   inn_done2, overs2, count2);
        end
      end
      ball2 = 1'b0;
      tick();
    end
    tests++;
    if (count2 !== 3'd0 || overs2 !== 6'd2 || inn_done2 !== 1'b1 || over_done2 !== 1'b0) begin
      fails++;
      $display("FAIL innings_hold: count=%0d overs=%0d id=%0b od=%0b required 0/2/1/0",
               count2, overs2, inn_done2, over_done2);
    end
  endtask

  task automatic test_random();
    int ref_balls = 0;
    int bad = 0;
    rst = 1'b1; ball = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    for (int s = 0; s < 100; s++) begin
      ball = 1'b1;
      ref_balls++;
      tick();
      tests++;
      if (int'(overs) * 6 + int'(count) != ref_balls) begin
        fails++;
        if (bad++ < 5)
          $display("FAIL random_strobe_%0d: overs*6+count=%0d required %0d",
                   s, int'(overs) * 6 + int'(count), ref_balls);
      end
      ball = 1'b0;
      for (int g = 0; g < int'($urandom_range(4, 1)); g++) begin
        tick();
        tests++;
        if (int'(overs) * 6 + int'(count) != ref_balls) begin
          fails++;
          if (bad++ < 5)
            $display("FAIL random_gap_%0d: overs*6+count=%0d required %0d",
                     s, int'(overs) * 6 + int'(count), ref_balls);
        end
      end
    end
    tests++;
    if (inn_done !== 1'b0 || overs !== 6'd16 || count !== 3'd4) begin
      fails++;
      $display("FAIL random_final: id=%0b overs=%0d count=%0d required 0/16/4",
               inn_done, overs, count);
    end
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1; ball = 1'b0; ball2 = 1'b0;
    test_reset();
    test_strobes();
    test_hold();
    test_reset_priority();
    test_innings_end();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_ball_counter
